// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register (Q / Q_bar) among N requesters.
// Optional macro SHARED_REG_BURST_EN adds a LOCK input for back-to-back owner writes.
module shared_reg_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int OW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           CK,
  input  logic           RST_N,
`ifdef SHARED_REG_BURST_EN
  input  logic [N-1:0]   LOCK,
`endif
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] D_IN,
  output logic [N-1:0]   GNT,
  output logic           ACK,
  output logic [OW-1:0]  OWNER,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   Q_bar
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] win;
  logic [OW-1:0] ptr_next;
  logic          burst;

  // Rotating-priority scan starting at ptr; the first requester found wins.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    logic found;
    int   idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && REQ[idx]) begin
        win   = OW'(idx);
        found = 1'b1;
      end
    end
  end

  // The pointer moves one past the owner so the owner drops to lowest priority.
  always_comb begin
    ptr_next = (OWNER == OW'(N - 1)) ? '0 : OWNER + OW'(1);
  end

`ifdef SHARED_REG_BURST_EN
  always_comb begin
    burst = REQ[OWNER] && LOCK[OWNER];
  end
`else
  always_comb begin
    burst = 1'b0;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  // NOTE: the shared register Q is reset along with the control state so that
  // Q/Q_bar are defined immediately after reset without waiting for a clock.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= '0;
      OWNER <= '0;
      GNT   <= '0;
      ACK   <= 1'b0;
      Q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ACK <= 1'b0;
          if (REQ != '0) begin
            state <= GRANT;
            OWNER <= win;
            GNT   <= N'(1) << win;
          end else begin
            GNT <= '0;
          end
        end

        GRANT: begin
          if (REQ[OWNER]) begin
            state <= DONE;
            Q     <= D_IN[int'(OWNER)*W +: W];
            ACK   <= 1'b1;
          end else begin
            // Withdrawn request: drop the grant and leave Q and ptr untouched.
            state <= IDLE;
            GNT   <= '0;
            ACK   <= 1'b0;
          end
        end

        DONE: begin
          ACK <= 1'b0;
          if (burst) begin
            state <= GRANT;
          end else begin
            state <= IDLE;
            ptr   <= ptr_next;
            GNT   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          GNT   <= '0;
          ACK   <= 1'b0;
        end
      endcase
    end
  end

  assign Q_bar = ~Q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N = 4, W = 8).
// Each scenario task drives stimulus and compares outputs against hand-computed values.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           CK;
  logic           RST_N;
  logic [N-1:0]   LOCK;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] D_IN;
  logic [N-1:0]   GNT;
  logic           ACK;
  logic [1:0]     OWNER;
  logic [W-1:0]   Q;
  logic [W-1:0]   Q_bar;

  int checks = 0;
  int errors = 0;

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .CK    (CK),
    .RST_N (RST_N),
`ifdef SHARED_REG_BURST_EN
    .LOCK  (LOCK),
`endif
    .REQ   (REQ),
    .D_IN  (D_IN),
    .GNT   (GNT),
    .ACK   (ACK),
    .OWNER (OWNER),
    .Q     (Q),
    .Q_bar (Q_bar)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // One complete access from IDLE: grant, write + ACK, back to IDLE.
  task automatic do_write(input logic [3:0] req, input logic [1:0] exp_owner,
                          input logic [7:0] exp_q, input bit hold, input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << exp_owner;
    REQ = req;
    tick();
    checks++; if (GNT !== exp_gnt) begin errors++; $display("FAIL %s_gnt: got %b expected %b", tag, GNT, exp_gnt); end
    checks++; if (OWNER !== exp_owner) begin errors++; $display("FAIL %s_owner: got %0d expected %0d", tag, OWNER, exp_owner); end
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL %s_ack_grant: got %b expected 0", tag, ACK); end
    tick();
    checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL %s_ack_done: got %b expected 1", tag, ACK); end
    checks++; if (Q !== exp_q) begin errors++; $display("FAIL %s_q: got %h expected %h", tag, Q, exp_q); end
    checks++; if (Q_bar !== ~exp_q) begin errors++; $display("FAIL %s_qbar: got %h expected %h", tag, Q_bar, ~exp_q); end
    checks++; if (GNT !== exp_gnt) begin errors++; $display("FAIL %s_gnt_done: got %b expected %b", tag, GNT, exp_gnt); end
    if (!hold) REQ = '0;
    tick();
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL %s_ack_idle: got %b expected 0", tag, ACK); end
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL %s_gnt_idle: got %b expected 0000", tag, GNT); end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ = '0; LOCK = '0; D_IN = '0;
    #3;
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", GNT); end
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ACK); end
    checks++; if (OWNER !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", OWNER); end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", Q); end
    checks++; if (Q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar: got %h expected ff", Q_bar); end
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_idle_gnt: got %b expected 0000", GNT); end
  endtask

  task automatic test_round_robin();
    D_IN = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      logic [1:0] o;
      o = 2'(i % 4);
      do_write(4'b1111, o, 8'h10 + 8'(o), (i != 4), $sformatf("rr%0d", i));
    end
  endtask

  task automatic test_single();
    D_IN = {8'h33, 8'hA5, 8'h11, 8'h10};
    do_write(4'b0100, 2'd2, 8'hA5, 1'b0, "single");
  endtask

  task automatic test_wrap();
    D_IN = {8'hC3, 8'h00, 8'h00, 8'hC0};
    do_write(4'b1000, 2'd3, 8'hC3, 1'b0, "wrap_pre");
    do_write(4'b1001, 2'd0, 8'hC0, 1'b1, "wrap_first");
    do_write(4'b1001, 2'd3, 8'hC3, 1'b0, "wrap_second");
  endtask

  task automatic test_abort();
    D_IN = {8'h00, 8'h00, 8'h71, 8'h70};
    do_write(4'b0001, 2'd0, 8'h70, 1'b0, "abort_pre");
    REQ = 4'b0010;
    tick();
    checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL abort_gnt: got %b expected 0010", GNT); end
    REQ = 4'b0000;
    tick();
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", ACK); end
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL abort_gnt_drop: got %b expected 0000", GNT); end
    tick();
    checks++; if (Q !== 8'h70) begin errors++; $display("FAIL abort_q: got %h expected 70", Q); end
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL abort_ack_late: got %b expected 0", ACK); end
    do_write(4'b0011, 2'd1, 8'h71, 1'b0, "abort_after");
  endtask

  task automatic test_async_reset();
    D_IN = {8'h93, 8'h92, 8'h91, 8'h90};
    REQ = 4'b1111;
    tick();
    checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL areset_pre_gnt: got %b expected 0100", GNT); end
    #1 RST_N = 1'b0;
    #1;
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL areset_gnt: got %b expected 0000", GNT); end
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL areset_ack: got %b expected 0", ACK); end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL areset_q: got %h expected 00", Q); end
    checks++; if (Q_bar !== 8'hFF) begin errors++; $display("FAIL areset_qbar: got %h expected ff", Q_bar); end
    checks++; if (OWNER !== 2'd0) begin errors++; $display("FAIL areset_owner: got %0d expected 0", OWNER); end
    REQ = '0;
    #1 RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ACK !== 1'b0 || Q !== 8'h00) begin errors++; $display("FAIL areset_quiet%0d: got ack=%b q=%h expected ack=0 q=00", i, ACK, Q); end
    end
    // ptr is back at 0, so client 1 beats client 2.
    do_write(4'b0110, 2'd1, 8'h91, 1'b0, "areset_ptr");
  endtask

`ifdef SHARED_REG_BURST_EN
  task automatic test_burst();
    D_IN = {8'hE3, 8'h00, 8'hB1, 8'h00};
    do_write(4'b1000, 2'd3, 8'hE3, 1'b0, "burst_pre");
    D_IN = {8'hE3, 8'h00, 8'hB1, 8'h20};
    REQ = 4'b0011; LOCK = 4'b0001;
    tick();
    checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL burst_gnt: got %b expected 0001", GNT); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ACK !== 1'b1 || Q !== 8'h20 + 8'(i)) begin errors++; $display("FAIL burst_write%0d: got ack=%b q=%h expected ack=1 q=%h", i, ACK, Q, 8'h20 + 8'(i)); end
      D_IN[7:0] = 8'h21 + 8'(i);
      if (i == 2) begin LOCK = '0; REQ = 4'b0010; end
      tick();
      if (i < 2) begin
        checks++; if (ACK !== 1'b0 || GNT !== 4'b0001) begin errors++; $display("FAIL burst_regrant%0d: got ack=%b gnt=%b expected ack=0 gnt=0001", i, ACK, GNT); end
      end else begin
        checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL burst_release: got %b expected 0000", GNT); end
      end
    end
    do_write(4'b0010, 2'd1, 8'hB1, 1'b0, "burst_next");
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_abort();
    test_async_reset();
`ifdef SHARED_REG_BURST_EN
    test_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
